// File: rtl/od_pulse_rx.sv
// od_pulse_rx: open-drain pulse-width receiver; decodes bits, bus reset, and answers with a presence pulse.
// Byte valid 3 clocks after the line is sampled high; an unaccepted byte is overwritten and flagged as overrun.
module od_pulse_rx #(
  parameter int T_GLITCH = 4,
  parameter int T_BIT    = 60,
  parameter int T_RST    = 480,
  parameter int T_PW     = 30,
  parameter int T_PL     = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       din,
  output logic       drive_low,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       reset_seen,
  output logic       overrun,
  output logic       err
);

  localparam logic [15:0] W_GLITCH = 16'(T_GLITCH);
  localparam logic [15:0] W_BIT    = 16'(T_BIT);
  localparam logic [15:0] W_RST    = 16'(T_RST);
  localparam logic [15:0] W_PW     = 16'(T_PW);
  localparam logic [15:0] W_PL     = 16'(T_PL);

  typedef enum logic [1:0] {IDLE, LOW, PRES_WAIT, PRES_DRIVE} state_t;

  state_t      state, state_nx;
  logic        din_m, din_s;
  logic [15:0] cnt, cnt_nx;
  logic [1:0]  hold, hold_nx;
  logic        bit_stb, bit_stb_nx;
  logic        bit_val, bit_val_nx;
  logic        rst_det, err_det;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic [2:0]  bit_cnt;

  assign shift_nx = {bit_val, shift[7:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hold_nx    = hold;
    bit_stb_nx = 1'b0;
    bit_val_nx = 1'b0;
    rst_det    = 1'b0;
    err_det    = 1'b0;
    case (state)
      IDLE: begin
        // hold masks the synchronizer still carrying our own presence low
        if (hold != 2'd0) begin
          hold_nx = hold - 2'd1;
        end else if (!din_s) begin
          state_nx = LOW;
          cnt_nx   = 16'd1;
        end
      end
      LOW: begin
        if (!din_s) begin
          if (cnt != 16'hFFFF) cnt_nx = cnt + 16'd1;
        end else if (cnt >= W_RST) begin
          rst_det  = 1'b1;
          state_nx = PRES_WAIT;
          cnt_nx   = 16'd1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
          if (cnt >= W_GLITCH) begin
            bit_stb_nx = 1'b1;
            bit_val_nx = (cnt < W_BIT);
          end
        end
      end
      PRES_WAIT: begin
        if (!din_s) begin
          err_det  = 1'b1;
          state_nx = LOW;
          cnt_nx   = 16'd1;
        end else if (cnt == W_PW) begin
          state_nx = PRES_DRIVE;
          cnt_nx   = 16'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      PRES_DRIVE: begin
        if (cnt == W_PL) begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
          hold_nx  = 2'd2;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_m      <= 1'b1;
      din_s      <= 1'b1;
      cnt        <= '0;
      hold       <= '0;
      bit_stb    <= 1'b0;
      bit_val    <= 1'b0;
      drive_low  <= 1'b0;
      reset_seen <= 1'b0;
      err        <= 1'b0;
    end else begin
      din_m      <= din;
      din_s      <= din_m;
      cnt        <= cnt_nx;
      hold       <= hold_nx;
      bit_stb    <= bit_stb_nx;
      bit_val    <= bit_val_nx;
      drive_low  <= (state_nx == PRES_DRIVE);
      reset_seen <= rst_det;
      err        <= err_det;
    end
  end

  // decoded bit lands one clock after classification, so a reset and a bit never collide
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift      <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rst_det) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (bit_stb) begin
        shift   <= shift_nx;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (bit_stb && bit_cnt == 3'd7) begin
        data       <= shift_nx;
        data_valid <= 1'b1;
        overrun    <= data_valid && !data_ready;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
